// File: rtl/sprite_pkg.sv
// sprite_pkg: pixel field indices, init FSM encoding and the 16x16 default mole image (pixel x in bits [x*4 +: 4])
package sprite_pkg;
  localparam int PIX_R = 3;
  localparam int PIX_G = 2;
  localparam int PIX_B = 1;
  localparam int PIX_A = 0;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;
  localparam logic [63:0] DEFAULT_MOLE [16] = '{
    64'h0000000DD0000000,
    64'h00000DDDDDD00000,
    64'h0000DDDDDDDD0000,
    64'h000DDDDDDDDDD000,
    64'h00DD1FDDDDF1DD00,
    64'h0DDD11DDDDF1DDD0,
    64'h0DDDDDDBBDDDDDD0,
    64'h0DDDDDBBBBDDDDD0,
    64'h0DDDDDDFFDDDDDD0,
    64'h0DDDDDDFFDDDDDD0,
    64'h0DDDDDDDDDDDDDD0,
    64'hBDDDDDDDDDDDDDDB,
    64'hBBDDDDDDDDDDDDBB,
    64'h0DDDDDDDDDDDDDD0,
    64'h5555555555555555,
    64'h5555555555555555
  };
endpackage

// File: rtl/sprite_row_ram.sv
// sprite_row_ram: DEPTH x WIDTH row store; ports: clk_i, write (we_i, wa_i, wd_i), registered read (ra_i -> rd_o), read-before-write
module sprite_row_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [AW-1:0]    ra_i,
  output logic [WIDTH-1:0] rd_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    rd_o <= mem_q[ra_i];
  end
endmodule

// File: rtl/sprite_bank.sv
// sprite_bank: multi-sprite pixel store with default-image init; ports: clk_i, rst_i, row write (wr_*_i), pixel read (rd_req_i, shape_i, xcoord_i, ycoord_i, hflip_i), pix_o, pix_valid_o, busy_o
module sprite_bank
  import sprite_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int BPP = 4,
  parameter int NUM_SHAPES = 4,
  localparam int XW = $clog2(SPR_W),
  localparam int YW = $clog2(SPR_H),
  localparam int SW = NUM_SHAPES > 1 ? $clog2(NUM_SHAPES) : 1,
  localparam int RW = SPR_W * BPP
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_en_i,
  input  logic [SW-1:0]  wr_shape_i,
  input  logic [YW-1:0]  wr_row_i,
  input  logic [RW-1:0]  wr_data_i,
  input  logic           rd_req_i,
  input  logic [SW-1:0]  shape_i,
  input  logic [XW-1:0]  xcoord_i,
  input  logic [YW-1:0]  ycoord_i,
  input  logic           hflip_i,
  output logic [BPP-1:0] pix_o,
  output logic           pix_valid_o,
  output logic           busy_o
);
  localparam int DEPTH = NUM_SHAPES * SPR_H;
  localparam int AW = $clog2(DEPTH);
  localparam logic USE_MOLE = SPR_W == 16 && SPR_H == 16 && BPP == 4;
  function automatic logic [AW-1:0] row_addr(input logic [SW-1:0] s, input logic [YW-1:0] r);
    return AW'(s) * AW'(SPR_H) + AW'(r);
  endfunction
  state_e state_q;
  logic [AW-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) state_q <= ST_READY;
    end
  end
  assign busy_o = state_q == ST_INIT;
  // The init counter walks linear row addresses, so shape 0 occupies counts below SPR_H.
  logic [RW-1:0] init_row;
  if (USE_MOLE) begin : g_mole
    assign init_row = {1'b0, cnt_q} < (AW+1)'(SPR_H) ? DEFAULT_MOLE[cnt_q[3:0]] : '0;
  end else begin : g_zero
    assign init_row = '0;
  end
  logic wr_ok, rd_ok, rd_shape_ok, x_ok, we;
  logic [AW-1:0] wa, ra;
  logic [RW-1:0] wd, row_q;
  always_comb begin
    wr_ok = wr_en_i && state_q == ST_READY && {1'b0, wr_shape_i} < (SW+1)'(NUM_SHAPES);
    rd_ok = rd_req_i && state_q == ST_READY;
    rd_shape_ok = {1'b0, shape_i} < (SW+1)'(NUM_SHAPES);
    x_ok = {1'b0, xcoord_i} < (XW+1)'(SPR_W);
    we = busy_o || wr_ok;
    wa = busy_o ? cnt_q : row_addr(wr_shape_i, wr_row_i);
    wd = busy_o ? init_row : wr_data_i;
    ra = rd_shape_ok ? row_addr(shape_i, ycoord_i) : '0;
  end
  sprite_row_ram #(.DEPTH(DEPTH), .WIDTH(RW)) u_ram (
    .clk_i(clk_i),
    .we_i (we),
    .wa_i (wa),
    .wd_i (wd),
    .ra_i (ra),
    .rd_o (row_q)
  );
  logic           s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d, pix_valid_q;
  logic [XW-1:0]  s1_col_q, s1_col_d;
  logic [BPP-1:0] pix_q, pix_d;
  always_comb begin
    s1_valid_d = rd_ok;
    s1_hit_d = rd_shape_ok && x_ok;
    s1_col_d = hflip_i ? XW'(SPR_W - 1) - xcoord_i : xcoord_i;
    pix_d = s1_valid_q && s1_hit_q ? row_q[s1_col_q*BPP +: BPP] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_hit_q <= 1'b0;
      s1_col_q <= '0;
      pix_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hit_q <= s1_hit_d;
      s1_col_q <= s1_col_d;
      pix_q <= pix_d;
      pix_valid_q <= s1_valid_q;
    end
  end
  assign pix_o = pix_q;
  assign pix_valid_o = pix_valid_q;
endmodule

// File: tb/tb_sprite_bank.sv
// tb_sprite_bank: scoreboard bench for sprite_bank (default 4-shape instance plus a 3-shape instance)
module tb_sprite_bank;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, wr_en3 = 1'b0, rd_req = 1'b0, rd_req3 = 1'b0, hflip = 1'b0;
  logic [1:0] wr_shape = '0, shape = '0;
  logic [3:0] wr_row = '0, xcoord = '0, ycoord = '0;
  logic [63:0] wr_data = '0;
  logic [3:0] pix, pix3;
  logic pix_valid, pix_valid3, busy, busy3;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [3:0] pix; int due;} exp_t;
  exp_t sb[$];
  logic [63:0] mole [16] = '{
    64'h0000000DD0000000, 64'h00000DDDDDD00000, 64'h0000DDDDDDDD0000, 64'h000DDDDDDDDDD000,
    64'h00DD1FDDDDF1DD00, 64'h0DDD11DDDDF1DDD0, 64'h0DDDDDDBBDDDDDD0, 64'h0DDDDDBBBBDDDDD0,
    64'h0DDDDDDFFDDDDDD0, 64'h0DDDDDDFFDDDDDD0, 64'h0DDDDDDDDDDDDDD0, 64'hBDDDDDDDDDDDDDDB,
    64'hBBDDDDDDDDDDDDBB, 64'h0DDDDDDDDDDDDDD0, 64'h5555555555555555, 64'h5555555555555555
  };
  sprite_bank dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_shape_i(wr_shape), .wr_row_i(wr_row),
    .wr_data_i(wr_data), .rd_req_i(rd_req), .shape_i(shape), .xcoord_i(xcoord),
    .ycoord_i(ycoord), .hflip_i(hflip), .pix_o(pix), .pix_valid_o(pix_valid), .busy_o(busy)
  );
  sprite_bank #(.NUM_SHAPES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en3), .wr_shape_i(wr_shape), .wr_row_i(wr_row),
    .wr_data_i(wr_data), .rd_req_i(rd_req3), .shape_i(shape), .xcoord_i(xcoord),
    .ycoord_i(ycoord), .hflip_i(hflip), .pix_o(pix3), .pix_valid_o(pix_valid3), .busy_o(busy3)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pix_valid) begin
      total++;
      assert (sb.size() > 0) else begin bad++; $error("FAIL unexpected_valid got pix=%h exp no result", pix); end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (pix === e.pix && cyc === e.due)
        else begin bad++; $error("FAIL read got pix=%h cyc=%0d exp pix=%h cyc=%0d", pix, cyc, e.pix, e.due); end
      end
    end else begin
      total++;
      assert (pix === 4'h0) else begin bad++; $error("FAIL idle_pix got=%h exp=0", pix); end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin bad++; $error("FAIL %s got=%h exp=%h", tag, got, exp); end
  endtask
  task automatic rd(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y, input logic hf, input logic [3:0] e);
    exp_t t;
    rd_req = 1'b1; shape = s; xcoord = x; ycoord = y; hflip = hf;
    t.pix = e;
    t.due = cyc + 2;
    sb.push_back(t);
    tick();
    rd_req = 1'b0;
  endtask
  task automatic rd3(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y, input logic [3:0] e);
    rd_req3 = 1'b1; shape = s; xcoord = x; ycoord = y; hflip = 1'b0;
    tick();
    rd_req3 = 1'b0;
    tick();
    chk("rd3_valid", 64'(pix_valid3), 64'd1);
    chk("rd3_pix", 64'(pix3), 64'(e));
  endtask
  task automatic wait_init();
    int n = 0;
    while (busy && n < 200) begin
      total++;
      assert (pix_valid === 1'b0) else begin bad++; $error("FAIL init_valid got=%b exp=0", pix_valid); end
      tick();
      n++;
    end
    total++;
    assert (n === 64) else begin bad++; $error("FAIL init_len got=%0d exp=64", n); end
  endtask
  initial begin
    tick();
    chk("rst_pix", 64'(pix), 64'd0);
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_busy3", 64'(busy3), 64'd1);
    rst = 1'b0;
    rd_req = 1'b1;
    wait_init();
    rd_req = 1'b0;
    chk("busy3_done", 64'(busy3), 64'd0);
    for (int x = 0; x < 16; x++) rd(2'd0, 4'(x), 4'd5, 1'b0, mole[5][x*4 +: 4]);
    rd(2'd0, 4'd0, 4'd5, 1'b1, mole[5][60 +: 4]);
    rd(2'd0, 4'd4, 4'd5, 1'b1, mole[5][44 +: 4]);
    rd(2'd1, 4'd3, 4'd9, 1'b0, 4'h0);
    wr_en = 1'b1; wr_shape = 2'd2; wr_row = 4'd3; wr_data = 64'h0123456789ABCDEF;
    tick();
    wr_en = 1'b0;
    rd(2'd2, 4'd1, 4'd3, 1'b0, 4'hE);
    rd(2'd2, 4'd1, 4'd3, 1'b1, 4'h1);
    rd(2'd2, 4'd15, 4'd3, 1'b0, 4'h0);
    rd(2'd2, 4'd0, 4'd3, 1'b0, 4'hF);
    wr_en = 1'b1; wr_shape = 2'd1; wr_row = 4'd0; wr_data = '1;
    rd(2'd1, 4'd0, 4'd0, 1'b0, 4'h0);
    wr_en = 1'b0;
    rd(2'd1, 4'd0, 4'd0, 1'b0, 4'hF);
    rd(2'd1, 4'd0, 4'd1, 1'b0, 4'h0);
    repeat (4) tick();
    rd3(2'd3, 4'd0, 4'd0, 4'h0);
    wr_en3 = 1'b1; wr_shape = 2'd3; wr_row = 4'd0; wr_data = '1;
    tick();
    wr_en3 = 1'b0;
    rd3(2'd3, 4'd0, 4'd0, 4'h0);
    rd3(2'd0, 4'd7, 4'd0, mole[0][28 +: 4]);
    rd3(2'd2, 4'd0, 4'd0, 4'h0);
    rd3(2'd1, 4'd5, 4'd0, 4'h0);
    rd_req = 1'b1; shape = 2'd1; xcoord = 4'd0; ycoord = 4'd7; hflip = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd1);
    chk("rst_mid_valid", 64'(pix_valid), 64'd0);
    wait_init();
    rd(2'd1, 4'd0, 4'd0, 1'b0, 4'h0);
    rd(2'd0, 4'd3, 4'd5, 1'b0, mole[5][12 +: 4]);
    repeat (4) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
